pc_fetch: RTL
=============

Name: pc_fetch

Overview:
- Instruction-fetch stage directly upstream of the PC/ID pipeline register.
- Owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents registered pc_pc/pc_inst to the PC/ID register.
- Honours the shared 6-bit stall vector, branch redirects from ID, and pipeline flushes from the exception unit.
- Inserts NOP bubbles (32'h0) when no fetched instruction is ready.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_id_stall  in  6  shared stall vector. Bit 0 = fetch stage, bit 1 = PC/ID register. Bit i set implies all lower bits set.
- flush  in  1  exception flush; highest priority.
- flush_pc  in  32  redirect address qualifying flush.
- id_branch_flag  in  1  taken branch resolved in ID.
- id_branch_target  in  32  branch target qualifying id_branch_flag.
- im_req  out  1  instruction memory request.
- im_addr  out  32  request address; stable while im_req=1.
- im_ack  in  1  memory response valid; may assert in the first im_req cycle.
- im_rdata  in  32  instruction word, valid with im_ack.
- pc_pc  out  32  address of the presented instruction.
- pc_inst  out  32  presented instruction; 0 = bubble.

Behaviour:
Reset (asynchronous, reset_n low):
- im_req=0, im_addr=0, pc_pc=0, pc_inst=0.
- Internal pc=RESET_VECTOR; state=IDLE; hold buffer empty; discard=0; redirect-pending=0.

FSM states: IDLE (no request outstanding) and WAIT (im_req=1).
- IDLE→WAIT at an edge where pc_id_stall[0]=0 and the hold buffer is empty (or drains this edge). That edge sets im_req<=1 and im_addr<=pc.
- WAIT with im_ack=0: stay in WAIT; im_req and im_addr held unchanged.
- WAIT with im_ack=1:
  - pc<=next pc.
  - If the reissue condition (same as IDLE→WAIT) holds, reissue immediately at next pc and stay in WAIT (back-to-back, one fetch per cycle).
  - Otherwise im_req<=0 and go to IDLE.
- A request, once issued, is never withdrawn.

Next pc, in priority order:
1. flush → flush_pc.
2. Pending redirect → its target.
3. id_branch_flag at an edge with pc_id_stall[0]=0 → id_branch_target.
4. Otherwise pc + PC_STEP (32-bit, wraps modulo 2^32).

Redirect timing:
- If flush or a branch arrives while in WAIT without ack, the target is stored as redirect-pending and applied at the ack edge. A flush overwrites a pending branch.

Output register (updates only at edges with pc_id_stall[1]=0), in priority order:
1. Hold buffer full → load it.
2. Non-discarded ack this edge → load (im_addr, im_rdata).
3. Otherwise → pc_inst<=0, pc_pc unchanged.
- While pc_id_stall[1]=1, outputs hold. A non-discarded ack arriving then goes to the one-entry hold buffer.

Flush edge:
- pc_inst<=0 and the hold buffer is cleared.
- If in WAIT and no ack this edge, discard<=1: the next ack's data is dropped and discard clears.
- If flush coincides with an ack, that data is dropped.
- flush overrides id_branch_flag on the same edge.

Latency: ack edge → pc_inst visible the same cycle after that edge (one-cycle registered).

Optional Feature:
- Macro PC_FETCH_PERF_EN.
- Defined: adds outputs pc_fetch_cnt[31:0] and pc_wait_cnt[31:0], both reset to 0.
  - pc_fetch_cnt increments on each non-discarded ack.
  - pc_wait_cnt increments on each WAIT cycle with im_ack=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=1'b0, WAIT=1'b1);
  - NOP word 32'h0;
  - RESET_VECTOR default;
  - stall bit indices STALL_PC=0, STALL_ID=1.
- One natural sub-module, pc_fetch_hold: the one-entry hold buffer (valid + 64-bit pc/inst) with load/drain/clear.

Test Plan:
- Release reset, im_ack tied 1 → im_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles. pc_inst follows im_rdata one cycle later; first output after reset is 0/0.
- im_ack delayed 3 cycles on 0xBFC00000 → im_addr stable for 4 cycles; pc_inst=0 for 3 edges; then data appears with pc_pc=0xBFC00000.
- Assert pc_id_stall=6'b000011 for 2 cycles while an ack lands → outputs frozen; data held in buffer; no new im_req; buffer drains at the first edge with stall cleared.
- id_branch_flag with target 0x80000100 during WAIT, ack 2 cycles later → the next request address is 0x80000100.
- flush with flush_pc 0xBFC00380 during WAIT → pc_inst=0 next cycle; the outstanding ack's data is never presented; the next im_addr is 0xBFC00380.
- Assert reset_n low mid-WAIT → im_req drops immediately; after release the fetch restarts at 0xBFC00000. With PC_FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the pc_fetch instruction-fetch stage: state encoding,
// bubble word, reset vector default, stall-vector bit positions.
package pc_fetch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

   localparam int STALL_PC = 0;
   localparam int STALL_ID = 1;

   // Sequential fetch address; wraps modulo 2^32 by construction.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc, input logic [31:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/pc_fetch_hold.sv
// One-entry skid buffer holding an acknowledged {pc, inst} pair while the
// PC/ID register is stalled; clear has priority over load and drain.
module pc_fetch_hold
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_inst,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] inst
);

   logic [63:0] data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

   // NOTE: the payload is qualified by valid, so it carries no reset and
   // lives in a separate clock-only process; only control state is reset.
   always_ff @(posedge clk) begin
      if (load) begin
         data <= {load_pc, load_inst};
      end
   end

   assign pc   = data[63:32];
   assign inst = data[31:0];

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, runs the im_req/im_ack handshake and
// feeds the PC/ID register. Optional counters under PC_FETCH_PERF_EN.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [31:0] PC_STEP      = 32'd4
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  pc_id_stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        id_branch_flag,
   input  logic [31:0] id_branch_target,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] pc_pc,
   output logic [31:0] pc_inst
`ifdef PC_FETCH_PERF_EN
  ,output logic [31:0] pc_fetch_cnt,
   output logic [31:0] pc_wait_cnt
`endif
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic         req_nxt;
   logic [31:0]  addr_nxt;
   logic         redir_pend, redir_pend_nxt;
   logic [31:0]  redir_target, redir_target_nxt;
   logic         discard, discard_nxt;

   logic         stall_pc, stall_id;
   logic         ack_edge, keep_data, branch_take, issue_ok;
   logic         hold_valid, hold_load, hold_drain;
   logic [31:0]  hold_pc, hold_inst;

   assign stall_pc    = pc_id_stall[STALL_PC];
   assign stall_id    = pc_id_stall[STALL_ID];
   assign ack_edge    = (state == WAIT) && im_ack;
   assign keep_data   = ack_edge && !discard && !flush;
   assign branch_take = id_branch_flag && !stall_pc;
   // Stall bits are nested, so an unstalled fetch also drains the buffer.
   assign issue_ok    = !stall_pc && (!hold_valid || !stall_id);
   assign hold_load   = keep_data && stall_id;
   assign hold_drain  = hold_valid && !stall_id;

   // NOTE: every always_comb output gets its hold value first so that no
   // path leaves a variable unassigned, which would infer a latch.
   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc;
      req_nxt          = im_req;
      addr_nxt         = im_addr;
      redir_pend_nxt   = redir_pend;
      redir_target_nxt = redir_target;
      discard_nxt      = discard;

      if (state == IDLE) begin
         if (flush) begin
            pc_nxt = flush_pc;
         end else if (branch_take) begin
            pc_nxt = id_branch_target;
         end
         if (issue_ok) begin
            state_nxt = WAIT;
            req_nxt   = 1'b1;
            addr_nxt  = pc_nxt;
         end
      end else if (im_ack) begin
         if (flush) begin
            pc_nxt = flush_pc;
         end else if (redir_pend) begin
            pc_nxt = redir_target;
         end else if (branch_take) begin
            pc_nxt = id_branch_target;
         end else begin
            pc_nxt = seq_pc(pc, PC_STEP);
         end
         redir_pend_nxt = 1'b0;
         discard_nxt    = 1'b0;
         if (issue_ok) begin
            addr_nxt = pc_nxt;
         end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      end else begin
         // Request is in flight and cannot be withdrawn: park the redirect.
         if (flush) begin
            redir_pend_nxt   = 1'b1;
            redir_target_nxt = flush_pc;
            discard_nxt      = 1'b1;
         end else if (branch_take && !redir_pend) begin
            redir_pend_nxt   = 1'b1;
            redir_target_nxt = id_branch_target;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // sample the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         pc           <= RESET_VECTOR;
         im_req       <= 1'b0;
         im_addr      <= '0;
         redir_pend   <= 1'b0;
         redir_target <= '0;
         discard      <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         im_req       <= req_nxt;
         im_addr      <= addr_nxt;
         redir_pend   <= redir_pend_nxt;
         redir_target <= redir_target_nxt;
         discard      <= discard_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_pc   <= '0;
         pc_inst <= NOP_INST;
      end else if (flush) begin
         pc_inst <= NOP_INST;
      end else if (!stall_id) begin
         if (hold_valid) begin
            pc_pc   <= hold_pc;
            pc_inst <= hold_inst;
         end else if (keep_data) begin
            pc_pc   <= im_addr;
            pc_inst <= im_rdata;
         end else begin
            pc_inst <= NOP_INST;
         end
      end
   end

   pc_fetch_hold u_hold (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (hold_load),
      .drain     (hold_drain),
      .clear     (flush),
      .load_pc   (im_addr),
      .load_inst (im_rdata),
      .valid     (hold_valid),
      .pc        (hold_pc),
      .inst      (hold_inst)
   );

`ifdef PC_FETCH_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_fetch_cnt <= '0;
         pc_wait_cnt  <= '0;
      end else begin
         if (keep_data && (pc_fetch_cnt != 32'hFFFF_FFFF)) begin
            pc_fetch_cnt <= pc_fetch_cnt + 32'd1;
         end
         if ((state == WAIT) && !im_ack && (pc_wait_cnt != 32'hFFFF_FFFF)) begin
            pc_wait_cnt <= pc_wait_cnt + 32'd1;
         end
      end
   end
`else
   // Counters are not built; the fetch datapath above is unchanged.
`endif

endmodule
